score_keeper: RTL and testbench
===============================

// Module: score_keeper
// PURPOSE
//  Game-side score/level tracker feeding the seven-segment score display stage.
//  Counts collected marshmallows as 3-digit packed BCD (000-999) and derives a level (1-7).
//  Level advances every LEVEL_STEP points. Tracks game phase (IDLE/PLAY/OVER).
//  Optionally retains a high score across games.
// PARAMETERS
//  LEVEL_STEP  10  points per level advance; legal range 1-99.
//  LEVEL_MAX   7   saturation level; fits the 3-bit level bus.
// PORTS
//  Clocking: one clock; reset is synchronous and active-high.
//  clock       in   1   system clock; all state changes on posedge.
//  reset       in   1   synchronous, active-high; full clear incl. high score.
//  new_game    in   1   1-cycle pulse; start/restart a game.
//  point       in   1   1-cycle pulse; one marshmallow collected (+1).
//  game_over   in   1   1-cycle pulse; player died.
//  score       out  12  packed BCD {hundreds,tens,ones}; display-ready.
//  level       out  3   current level, 1..LEVEL_MAX (0 only while in IDLE after reset).
//  playing     out  1   high in PLAY state.
//  level_up    out  1   1-cycle pulse, aligned with the cycle level changes.
//  high_score  out  12  packed BCD best score (macro-gated, see CONFIGURATION).
//  new_record  out  1   1-cycle pulse when high_score is updated (macro-gated).
// BEHAVIOUR
//  Reset: state=IDLE, score=12'h000, level=0, playing=0, pulses=0, high_score=12'h000.
//  FSM:
//   IDLE -new_game-> PLAY
//   PLAY -game_over-> OVER
//   OVER -new_game-> PLAY
//   PLAY -new_game-> PLAY (restart)
//  On new_game: score<=000, level<=1, in-level count<=0, state<=PLAY.
//   This happens in any state, next edge.
//  point in PLAY: registered, visible next cycle (latency 1).
//   BCD ones rolls 9->0 with carry into tens; tens 9->0 carries into hundreds.
//  Saturation: score at 12'h999 stays 999. Further points are ignored, including for leveling.
//  Level: internal binary count (7b) increments per accepted point.
//   When it reaches LEVEL_STEP it clears to 0, level+1, and level_up=1 for that cycle.
//   At LEVEL_MAX the count keeps wrapping, but level holds and no level_up is issued.
//  point outside PLAY: ignored; score holds.
//  game_over outside PLAY: ignored.
//  Simultaneous events:
//   new_game + point: new_game wins, point dropped.
//   new_game + game_over: new_game wins.
//   point + game_over in PLAY: point counted, then OVER (score includes it).
//  In OVER: score/level frozen and still driven, so the display shows the final result.
//  reset mid-game: full clear per reset list next edge; pulses in same cycle ignored.
// CONFIGURATION
//  HIGH_SCORE_EN defined:
//   On the PLAY->OVER transition edge, the final score (including any same-cycle point)
//    is compared as BCD. BCD compares correctly as unsigned.
//   If final > high_score: high_score<=final, new_record=1 for 1 cycle.
//   Cleared only by reset; new_game does not clear it.
//  HIGH_SCORE_EN undefined: no register; high_score tied 12'h000, new_record tied 0.
// STRUCTURE
//  Shared package score_pkg:
//   FSM state typedef {S_IDLE,S_PLAY,S_OVER}.
//   BCD_MAX=12'h999, LEVEL_W=3, SCORE_W=12.
//  Sub-module bcd_digit: 4-bit BCD digit with inc/carry_in, clr, carry_out (9->0).
//   Instantiated three times as a ripple chain.
//   The saturation check lives in score_keeper.
// TESTING
//  1. reset; new_game; 3 points -> score 12'h003, level 1, playing 1, no level_up.
//  2. LEVEL_STEP=10; 10 points from 0 -> score 12'h010, level 2, single level_up on 10th point.
//  3. 99 points -> 12'h099; 1 more -> 12'h100 (double carry).
//     Preload to 999, +1 -> stays 12'h999.
//  4. point+game_over same cycle at score 041 -> score 042, state OVER.
//     Later points ignored; with HIGH_SCORE_EN: high_score 12'h042 and new_record pulses.
//  5. Second game ends at 030 -> high_score stays 042, no new_record.
//     new_game+point same cycle -> score 000, level 1.
//  6. reset during PLAY at score 057, level 6 -> next cycle all outputs at reset values,
//     incl. high_score 000.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared types and constants for the score keeper slice.
// A file-scope package, imported by the interface and modules of this block.
package score_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_OVER
    } state_t;

    localparam int SCORE_W = 12;
    localparam int LEVEL_W = 3;
    localparam int CNT_W   = 7;
    localparam logic [SCORE_W-1:0] BCD_MAX = 12'h999;

    // Packed 3-digit BCD increment.
    // The hundreds digit wraps, but the caller never passes 999.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] s);
        logic [3:0] h, t, o;
        {h, t, o} = s;
        if (o != 4'd9) begin
            o = o + 4'd1;
        end else begin
            o = 4'd0;
            if (t != 4'd9) begin
                t = t + 4'd1;
            end else begin
                t = 4'd0;
                h = (h == 4'd9) ? 4'd0 : h + 4'd1;
            end
        end
        return {h, t, o};
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// Game-event / score-display bundle between the game logic and the score keeper.
// master drives the event pulses; slave (the score keeper) drives the results.
interface score_keeper_if;
    import score_pkg::*;

    logic                 new_game;
    logic                 point;
    logic                 game_over;
    logic [SCORE_W-1:0]   score;
    logic [LEVEL_W-1:0]   level;
    logic                 playing;
    logic                 level_up;
    logic [SCORE_W-1:0]   high_score;
    logic                 new_record;

    modport master (
        output new_game, point, game_over,
        input  score, level, playing, level_up, high_score, new_record
    );

    modport slave (
        input  new_game, point, game_over,
        output score, level, playing, level_up, high_score, new_record
    );

endinterface

// File: rtl/score_keeper_bcd_digit.sv
// One packed-BCD digit counter. Chain three of these for a 000-999 score.
// carry_out is combinational so the next digit steps on the same edge.
module bcd_digit (
    input  logic       clock,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry_out
);

    assign carry_out = inc && (q == 4'd9);

    // Digit register: clear wins over increment, and 9 rolls over to 0.
    always_ff @(posedge clock) begin
        if (clr) begin
            q <= 4'd0;
        end else if (inc) begin
            q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Score / level / game-phase tracker feeding the seven-segment score display.
// Optional feature macro: HIGH_SCORE_EN keeps a best-score register across games.
// When it is undefined, high_score reads 000 and new_record stays low.
module score_keeper
    import score_pkg::*;
#(
    parameter int LEVEL_STEP = 10,
    parameter int LEVEL_MAX  = 7
) (
    input  logic           clock,
    input  logic           reset,
    score_keeper_if.slave  bus
);

    state_t               state;
    logic [LEVEL_W-1:0]   level;
    logic [CNT_W-1:0]     level_cnt;
    logic                 playing;
    logic                 level_up;

    logic [3:0]           d_ones, d_tens, d_hund;
    logic                 c_ones, c_tens, hund_carry_unused;
    logic [SCORE_W-1:0]   score;
    logic                 accept;
    logic                 digit_clr;

    assign score = {d_hund, d_tens, d_ones};

    // A point counts only while playing, when not overridden by a restart,
    // and when the score is below 999. A point dropped at 999 also leaves the level count alone.
    assign accept    = (state == S_PLAY) && bus.point && !bus.new_game && (score != BCD_MAX);
    assign digit_clr = reset || bus.new_game;

    bcd_digit u_ones (
        .clock     (clock),
        .clr       (digit_clr),
        .inc       (accept),
        .q         (d_ones),
        .carry_out (c_ones)
    );

    bcd_digit u_tens (
        .clock     (clock),
        .clr       (digit_clr),
        .inc       (c_ones),
        .q         (d_tens),
        .carry_out (c_tens)
    );

    // The hundreds carry never fires, because 999 is never incremented.
    bcd_digit u_hund (
        .clock     (clock),
        .clr       (digit_clr),
        .inc       (c_tens),
        .q         (d_hund),
        .carry_out (hund_carry_unused)
    );

    // Phase FSM with level tracking and registered playing / level_up outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            level     <= '0;
            level_cnt <= '0;
            playing   <= 1'b0;
            level_up  <= 1'b0;
        end else begin
            level_up <= 1'b0;
            if (bus.new_game) begin
                state     <= S_PLAY;
                level     <= LEVEL_W'(1);
                level_cnt <= '0;
                playing   <= 1'b1;
            end else begin
                if (accept) begin
                    if (level_cnt == CNT_W'(LEVEL_STEP - 1)) begin
                        level_cnt <= '0;
                        if (level < LEVEL_W'(LEVEL_MAX)) begin
                            level    <= level + LEVEL_W'(1);
                            level_up <= 1'b1;
                        end
                    end else begin
                        level_cnt <= level_cnt + CNT_W'(1);
                    end
                end
                if ((state == S_PLAY) && bus.game_over) begin
                    state   <= S_OVER;
                    playing <= 1'b0;
                end
            end
        end
    end

`ifdef HIGH_SCORE_EN
    logic [SCORE_W-1:0]   high_score;
    logic                 new_record;
    logic [SCORE_W-1:0]   final_score;

    // The final score includes any point that arrives on the same edge as game_over.
    assign final_score = accept ? bcd_inc(score) : score;

    // Best-score register, updated on the PLAY->OVER edge.
    // Packed BCD orders correctly as an unsigned number.
    always_ff @(posedge clock) begin
        if (reset) begin
            high_score <= '0;
            new_record <= 1'b0;
        end else begin
            new_record <= 1'b0;
            if ((state == S_PLAY) && bus.game_over && !bus.new_game &&
                (final_score > high_score)) begin
                high_score <= final_score;
                new_record <= 1'b1;
            end
        end
    end

    assign bus.high_score = high_score;
    assign bus.new_record = new_record;
`else
    assign bus.high_score = '0;
    assign bus.new_record = 1'b0;
`endif

    assign bus.score    = score;
    assign bus.level    = level;
    assign bus.playing  = playing;
    assign bus.level_up = level_up;

endmodule

// File: tb/tb_score_keeper.sv
// Directed testbench for score_keeper: a vector table plus hand-written multi-cycle sequences.
module tb_score_keeper;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    score_keeper_if sif ();

    score_keeper #(
        .LEVEL_STEP (10),
        .LEVEL_MAX  (7)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif)
    );

`ifdef HIGH_SCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif

    typedef struct {
        logic        rs;
        logic        ng;
        logic        pt;
        logic        go;
        logic [11:0] score;
        logic [2:0]  level;
        logic        playing;
        logic        lu;
    } vec_t;

    vec_t vecs [15];
    int   checks   = 0;
    int   errors   = 0;
    int   lu_count = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs.
    // Outputs are sampled 1 time unit after the edge, then the pulses drop.
    task automatic step(input logic ng, input logic pt, input logic go, input logic rs);
        sif.new_game  = ng;
        sif.point     = pt;
        sif.game_over = go;
        reset         = rs;
        @(posedge clock);
        #1;
        sif.new_game  = 1'b0;
        sif.point     = 1'b0;
        sif.game_over = 1'b0;
        reset         = 1'b0;
        if (sif.level_up) lu_count++;
    endtask

    task automatic points(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        sif.new_game  = 1'b0;
        sif.point     = 1'b0;
        sif.game_over = 1'b0;

        // Table: reset, ignored IDLE events, new_game, then ten points with one level_up.
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 3'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 3'd0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 3'd1, 1'b1, 1'b0};
        for (int k = 1; k <= 9; k++)
            vecs[3+k] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'(k), 3'd1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 12'h010, 3'd2, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h010, 3'd2, 1'b1, 1'b0};

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].ng, vecs[i].pt, vecs[i].go, vecs[i].rs);
            chk($sformatf("vec%0d score", i), sif.score, vecs[i].score);
            chk($sformatf("vec%0d level", i), sif.level, vecs[i].level);
            chk($sformatf("vec%0d playing", i), sif.playing, vecs[i].playing);
            chk($sformatf("vec%0d level_up", i), sif.level_up, vecs[i].lu);
            if (i == 0) begin
                chk("reset high_score", sif.high_score, 0);
                chk("reset new_record", sif.new_record, 0);
            end
        end

        // Double carry into hundreds, then saturation at 999 with the level held at 7.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        lu_count = 0;
        points(99);
        chk("s3 score 099", sif.score, 12'h099);
        chk("s3 level 99pts", sif.level, 7);
        points(1);
        chk("s3 score 100", sif.score, 12'h100);
        points(899);
        chk("s3 score 999", sif.score, 12'h999);
        points(1);
        chk("s3 score sat", sif.score, 12'h999);
        chk("s3 level sat", sif.level, 7);
        chk("s3 level_up total", lu_count, 6);

        // A point and game_over in the same cycle at 041.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        points(41);
        chk("s4 score 041", sif.score, 12'h041);
        chk("s4 level", sif.level, 5);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("s4 score 042", sif.score, 12'h042);
        chk("s4 playing", sif.playing, 0);
        chk("s4 high_score", sif.high_score, HS_EN ? 12'h042 : 12'h000);
        chk("s4 new_record", sif.new_record, HS_EN ? 1 : 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("s4 new_record drop", sif.new_record, 0);
        chk("s4 over point", sif.score, 12'h042);
        chk("s4 over level", sif.level, 5);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("s4 over go", sif.playing, 0);

        // A lower second game keeps the record, then the same-cycle priority cases.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("s5 restart score", sif.score, 12'h000);
        chk("s5 hs kept", sif.high_score, HS_EN ? 12'h042 : 12'h000);
        points(30);
        chk("s5 level", sif.level, 4);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("s5 score 030", sif.score, 12'h030);
        chk("s5 hs stays", sif.high_score, HS_EN ? 12'h042 : 12'h000);
        chk("s5 no record", sif.new_record, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("s5 ng+pt score", sif.score, 12'h000);
        chk("s5 ng+pt level", sif.level, 1);
        chk("s5 ng+pt playing", sif.playing, 1);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("s5 ng+go playing", sif.playing, 1);

        // Reset in the middle of a game at 057.
        points(57);
        chk("s6 score 057", sif.score, 12'h057);
        chk("s6 level 6", sif.level, 6);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk("s6 rst score", sif.score, 12'h000);
        chk("s6 rst level", sif.level, 0);
        chk("s6 rst playing", sif.playing, 0);
        chk("s6 rst level_up", sif.level_up, 0);
        chk("s6 rst high_score", sif.high_score, 12'h000);
        chk("s6 rst new_record", sif.new_record, 0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("s6 idle point", sif.score, 12'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
